register_fetch: RTL
===================

REGISTER_FETCH -- requirements
Module: register_fetch

Interface
REQ-001 The block SHALL take parameter REG_COUNT, default 128, giving the number of register table entries.
REQ-002 The block SHALL take parameter WIDTH, default 128, giving the register width in bits.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port stall  input  1  hold output stage.
REQ-006 The block SHALL have port flush  input  1  squash the instruction entering the output stage.
REQ-007 The block SHALL have ports op_in 11, format_in 3, rt_addr_in 7, imm_in 18, reg_write_in 1 (all input), carrying the decoded instruction.
REQ-008 The block SHALL have ports ra_addr_in and rb_addr_in  input  7  source register addresses.
REQ-009 The block SHALL have ports wb_even_data  input  WIDTH, wb_even_addr  input  7 and wb_even_we  input  1, carrying the even-pipe writeback.
REQ-010 The block SHALL have ports wb_odd_data  input  WIDTH, wb_odd_addr  input  7 and wb_odd_we  input  1, carrying the odd-pipe writeback (Permute unit rt_wb/rt_addr_wb/reg_write_wb).
REQ-011 The block SHALL have ports op 11, format 3, rt_addr 7, ra WIDTH, rb WIDTH, imm 18, reg_write 1 (all output, registered), feeding the execution units.

Function
REQ-012 Register table: REG_COUNT x WIDTH; no hardwired-zero entry; address 0 is an ordinary register.
REQ-013 Write: on a rising edge with wb_X_we=1, table[wb_X_addr] <= wb_X_data; both ports may write in the same cycle.
REQ-014 Same-address dual write: odd port wins; the even data is discarded.
REQ-015 Read bypass (combinational): source value = wb_odd_data if wb_odd_we and addr match; else wb_even_data if wb_even_we and addr match; else table entry.
REQ-016 Latency: fields presented in cycle N appear on the outputs after edge N+1 (1 cycle), with bypassed sources.
REQ-017 Capture: with stall=0 and flush=0, all outputs load their *_in fields and bypassed ra/rb on each edge.
REQ-018 Stall: with stall=1, op, format, rt_addr, imm and reg_write hold; held source addresses are retained internally.
REQ-019 Stall refresh: while stalled, if a writeback in that cycle targets a held source address, ra/rb SHALL load the written value (odd priority per REQ-014), so no stale operand leaves the stage.
REQ-020 Flush: flush=1 loads op=0 (nop), reg_write=0 and all other outputs 0 on the next edge; flush overrides stall.
REQ-021 When ra_addr_in equals rb_addr_in, both outputs SHALL receive the identical bypassed value.
REQ-022 Writebacks SHALL proceed regardless of stall or flush.

Reset
REQ-023 With reset=1 at a rising edge, all outputs SHALL be 0 (op=nop, reg_write=0), all table entries 0 and held addresses 0; reset overrides flush, stall and writes.
REQ-024 Reset asserted mid-stall SHALL discard the held instruction; the first edge after deassertion SHALL capture normally.

Structure
REQ-025 Shared package SHALL hold REG_COUNT, WIDTH, the op/format/imm widths, the NOP opcode constant and the register-address typedef.
REQ-026 One sub-module, regfile_2w2r (table plus REQ-013..015 bypass), SHALL be instantiated; output staging stays in register_fetch.

Verification
REQ-027 Reset, then read r3 via ra -> ra=0 one cycle later; every output 0 during reset.
REQ-028 wb_odd writes r3=128'h0001..0001 while ra_addr_in=3 in the same cycle -> ra=128'h0001..0001 after the next edge (bypass).
REQ-029 Both ports write r5 (even=all-F, odd=128'h...FE) -> subsequent read of r5 returns 128'h...FE.
REQ-030 stall=1 with rb_addr_in=7; wb_even writes r7=128'h00FF in that cycle -> rb=128'h00FF; op unchanged.
REQ-031 op_in=11'b00111011011 with flush=1 and stall=1 -> op=0, reg_write=0; writes in that cycle still land.
REQ-032 reset pulsed during stall -> outputs 0; next unstalled instruction appears after 1 cycle.

Source files
------------

// File: rtl/register_fetch_pkg.sv
// Shared sizes, opcode constants and address type for the register fetch stage.
package register_fetch_pkg;

  localparam int unsigned REG_COUNT = 128;
  localparam int unsigned WIDTH     = 128;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned OP_W      = 11;
  localparam int unsigned FMT_W     = 3;
  localparam int unsigned IMM_W     = 18;

  localparam logic [OP_W-1:0] OP_NOP = '0;

  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_fetch_regfile_2w2r.sv
// Register table with two write ports (even/odd pipes) and two bypassed read ports.
module regfile_2w2r
  import register_fetch_pkg::*;
#(
  parameter int unsigned REG_COUNT = register_fetch_pkg::REG_COUNT,
  parameter int unsigned WIDTH     = register_fetch_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wb_even_data,
  input  reg_addr_t        wb_even_addr,
  input  logic             wb_even_we,
  input  logic [WIDTH-1:0] wb_odd_data,
  input  reg_addr_t        wb_odd_addr,
  input  logic             wb_odd_we,
  input  reg_addr_t        ra_addr,
  input  reg_addr_t        rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data
);

  logic [WIDTH-1:0] mem [REG_COUNT];

  // Table update: odd write is issued last so it wins on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
    end else begin
      if (wb_even_we) mem[wb_even_addr] <= wb_even_data;
      if (wb_odd_we)  mem[wb_odd_addr]  <= wb_odd_data;
    end
  end

  // Read with same-cycle writeback bypass, odd pipe taking priority.
  always_comb begin
    ra_data = mem[ra_addr];
    rb_data = mem[rb_addr];
    if (wb_even_we && wb_even_addr == ra_addr) ra_data = wb_even_data;
    if (wb_odd_we  && wb_odd_addr  == ra_addr) ra_data = wb_odd_data;
    if (wb_even_we && wb_even_addr == rb_addr) rb_data = wb_even_data;
    if (wb_odd_we  && wb_odd_addr  == rb_addr) rb_data = wb_odd_data;
  end

endmodule

// File: rtl/register_fetch.sv
// Register fetch stage: reads operands with writeback bypass and registers the instruction.
module register_fetch
  import register_fetch_pkg::*;
#(
  parameter int unsigned REG_COUNT = register_fetch_pkg::REG_COUNT,
  parameter int unsigned WIDTH     = register_fetch_pkg::WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [OP_W-1:0]   op_in,
  input  logic [FMT_W-1:0]  format_in,
  input  reg_addr_t         rt_addr_in,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic              reg_write_in,
  input  reg_addr_t         ra_addr_in,
  input  reg_addr_t         rb_addr_in,
  input  logic [WIDTH-1:0]  wb_even_data,
  input  reg_addr_t         wb_even_addr,
  input  logic              wb_even_we,
  input  logic [WIDTH-1:0]  wb_odd_data,
  input  reg_addr_t         wb_odd_addr,
  input  logic              wb_odd_we,
  output logic [OP_W-1:0]   op,
  output logic [FMT_W-1:0]  format,
  output reg_addr_t         rt_addr,
  output logic [WIDTH-1:0]  ra,
  output logic [WIDTH-1:0]  rb,
  output logic [IMM_W-1:0]  imm,
  output logic              reg_write
);

  reg_addr_t        ra_hold, rb_hold;
  reg_addr_t        ra_rd_addr, rb_rd_addr;
  logic [WIDTH-1:0] ra_rd, rb_rd;
  logic             ra_hit, rb_hit;

  // While stalled the read ports follow the held addresses so a writeback can refresh them.
  always_comb begin
    ra_rd_addr = stall ? ra_hold : ra_addr_in;
    rb_rd_addr = stall ? rb_hold : rb_addr_in;
    ra_hit = (wb_even_we && wb_even_addr == ra_hold) || (wb_odd_we && wb_odd_addr == ra_hold);
    rb_hit = (wb_even_we && wb_even_addr == rb_hold) || (wb_odd_we && wb_odd_addr == rb_hold);
  end

  regfile_2w2r #(
    .REG_COUNT (REG_COUNT),
    .WIDTH     (WIDTH)
  ) u_regfile (
    .clk          (clk),
    .reset        (reset),
    .wb_even_data (wb_even_data),
    .wb_even_addr (wb_even_addr),
    .wb_even_we   (wb_even_we),
    .wb_odd_data  (wb_odd_data),
    .wb_odd_addr  (wb_odd_addr),
    .wb_odd_we    (wb_odd_we),
    .ra_addr      (ra_rd_addr),
    .rb_addr      (rb_rd_addr),
    .ra_data      (ra_rd),
    .rb_data      (rb_rd)
  );

  // Output stage: reset > flush > stall (hold, refresh hit operands) > capture.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      op        <= OP_NOP;
      format    <= '0;
      rt_addr   <= '0;
      ra        <= '0;
      rb        <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
      ra_hold   <= '0;
      rb_hold   <= '0;
    end else if (stall) begin
      if (ra_hit) ra <= ra_rd;
      if (rb_hit) rb <= rb_rd;
    end else begin
      op        <= op_in;
      format    <= format_in;
      rt_addr   <= rt_addr_in;
      ra        <= ra_rd;
      rb        <= rb_rd;
      imm       <= imm_in;
      reg_write <= reg_write_in;
      ra_hold   <= ra_addr_in;
      rb_hold   <= rb_addr_in;
    end
  end

endmodule
